// File: rtl/logic_pkg.sv
// Shared definitions for the logic unit pipeline.
// Holds the 3-bit gate operation encoding and the illegal op code constant.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6
  } gate_op_e;

  // Code 7 is not a member of the enum; it is decoded as an error result.
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_gate_eval.sv
// gate_eval: combinational bitwise gate evaluator.
// Ports:
//   a, b  operands (b ignored for NOT)
//   op    operation code (gate_op_e encoding)
//   y     result; zero for the illegal code
//   err   high only for the illegal code
module gate_eval
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    if (op == OP_ILLEGAL) begin
      err = 1'b1;
    end else begin
      case (gate_op_e'(op))
        OP_AND:  y = a & b;
        OP_OR:   y = a | b;
        OP_NOT:  y = ~a;
        OP_NAND: y = ~(a & b);
        OP_NOR:  y = ~(a | b);
        OP_XOR:  y = a ^ b;
        OP_XNOR: y = ~(a ^ b);
        default: y = '0;
      endcase
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline around a bitwise gate unit.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; a, b, op, chain are the payload
//   out_valid/out_ready output handshake; y, op_err are the payload
//   res_cnt             wrapping count of output transfers
// S1 registers the request; S2 evaluates it and holds the result until drained.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             op_err,
  output logic [CNT_W-1:0] res_cnt
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_chain;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_op_err;
  logic [CNT_W-1:0] r_res_cnt;

  logic             w_s2_load;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Chained ops take the y register as operand a. r_y is never cleared on
  // drain, so the previous result is still available after it has left.
  assign w_a_eff = r_s1_chain ? r_y : r_s1_a;

  gate_eval #(.WIDTH(WIDTH)) u_gate_eval (
    .a   (w_a_eff),
    .b   (r_s1_b),
    .op  (r_s1_op),
    .y   (w_y),
    .err (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= 3'd0;
      r_s1_chain <= 1'b0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= op;
      r_s1_chain <= chain;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_op_err    <= 1'b0;
      r_res_cnt   <= '0;
    end else begin
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_y         <= w_y;
        r_op_err    <= w_err;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_out_xfer) begin
        r_res_cnt <= r_res_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign op_err    = r_op_err;
  assign res_cnt   = r_res_cnt;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             op_err;
  logic [CNT_W-1:0] res_cnt;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .chain     (chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .op_err    (op_err),
    .res_cnt   (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
    logic [7:0] y;
    logic       err;
  } vec_t;

  vec_t vecs[10];
  vec_t bp_vecs[4];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    op       = v.op;
    a        = v.a;
    b        = v.b;
    chain    = v.chain;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chain     = 1'b0;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_op_err", 64'(op_err), 64'd0);
    check("rst_res_cnt", 64'(res_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // One op with an idle pipe and out_ready=1: accept, out_valid exactly two
  // edges later, then drained on the following edge.
  task automatic run_vec(input vec_t v, input int idx, input int exp_cnt);
    drive(v);
    #1;
    check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check($sformatf("v%0d_lat1_valid", idx), 64'(out_valid), 64'd0);
    step();
    check($sformatf("v%0d_lat2_valid", idx), 64'(out_valid), 64'd1);
    check($sformatf("v%0d_y", idx), 64'(y), 64'(v.y));
    check($sformatf("v%0d_err", idx), 64'(op_err), 64'(v.err));
    step();
    check($sformatf("v%0d_drained", idx), 64'(out_valid), 64'd0);
    check($sformatf("v%0d_res_cnt", idx), 64'(res_cnt), 64'(exp_cnt));
  endtask

  initial begin
    int idx;
    int got;
    int cyc;
    logic xin;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; chain = 1'b0; out_ready = 1'b1;

    // Op sweep with a=C5, b=3A, then a two-step chain.
    vecs[0] = '{3'd0, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{3'd1, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0};
    vecs[2] = '{3'd2, 8'hC5, 8'h3A, 1'b0, 8'h3A, 1'b0};
    vecs[3] = '{3'd3, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{3'd4, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{3'd5, 8'hC5, 8'h3A, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{3'd6, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{3'd7, 8'hC5, 8'h3A, 1'b0, 8'h00, 1'b1};
    vecs[8] = '{3'd5, 8'h0F, 8'hFF, 1'b0, 8'hF0, 1'b0};
    vecs[9] = '{3'd5, 8'h55, 8'h0F, 1'b1, 8'hFF, 1'b0};

    bp_vecs[0] = '{3'd1, 8'h01, 8'h10, 1'b0, 8'h11, 1'b0};
    bp_vecs[1] = '{3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
    bp_vecs[2] = '{3'd5, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0};
    bp_vecs[3] = '{3'd2, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i, (i + 1) % 16);

    // Chain straight after reset: a=FF is ignored, operand comes from y=0.
    do_reset();
    run_vec('{3'd0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0}, 10, 1);

    // Backpressure: offer four ops back to back with out_ready low.
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) drive(bp_vecs[idx]); else in_valid = 1'b0;
      #1;
      xin = in_valid && in_ready;
      if (c >= 2) begin
        check($sformatf("bp_stall%0d_valid", c), 64'(out_valid), 64'd1);
        check($sformatf("bp_stall%0d_y", c), 64'(y), 64'h11);
        check($sformatf("bp_stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      end
      step();
      if (xin) idx++;
    end
    check("bp_accepted_while_stalled", 64'(idx), 64'd2);
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      if (idx < 4) drive(bp_vecs[idx]); else in_valid = 1'b0;
      #1;
      xin = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("bp_drain%0d_y", got), 64'(y), 64'(bp_vecs[got].y));
        got++;
      end
      step();
      if (xin) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_drain_count", 64'(got), 64'd4);
    check("bp_res_cnt", 64'(res_cnt), 64'd4);

    // Reset with two ops in flight: neither may emerge.
    do_reset();
    out_ready = 1'b0;
    drive(bp_vecs[0]);
    step();
    drive(bp_vecs[1]);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_res_cnt", 64'(res_cnt), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("flush_idle%0d_valid", c), 64'(out_valid), 64'd0);
    end
    check("flush_res_cnt_after", 64'(res_cnt), 64'd0);

    // 17 streamed transfers wrap the 4-bit counter to 1; full throughput.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive('{3'd1, 8'(i), 8'h00, 1'b0, 8'h00, 1'b0});
      #1;
      check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
      if (i >= 2) begin
        check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
        check($sformatf("stream%0d_y", i), 64'(y), 64'(i - 2));
      end
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("wrap_res_cnt", 64'(res_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
